// File: rtl/stack_pkg.sv
// Shared stack definitions: op codes and the issue/settle FSM state type,
// used by the stack, its arbiter and their benches.
package stack_pkg;

  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_PUSH = 4'd0;
  localparam logic [OP_W-1:0] OP_POP  = 4'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the first eligible index after ptr,
// wrapping cyclically. Reusable by any shared-resource arbiter.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // cand[k] is the index searched at priority position k (ptr+1 first).
  logic [IW-1:0] cand [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = IW'((int'(ptr) + gi + 1) % N);
    end
  endgenerate

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && eligible[cand[k]]) begin
        any   = 1'b1;
        idx   = cand[k];
        grant = N'(1) << cand[k];
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one stack between N clients (issue/settle/response).
// Optional STACK_ARB_GUARD_EN: local depth tracking rejects pop-on-empty / push-on-full.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 2,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [4*N-1:0]    req_op,
  input  logic [W*N-1:0]    req_in,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      done,
  output logic [W-1:0]      rsp_head,
  output logic              rsp_valid,
  output logic              rsp_empty,
  output logic [W-1:0]      stk_in,
  output logic [OP_W-1:0]   stk_op,
  output logic              stk_apply,
  input  logic [W-1:0]      stk_head,
  input  logic              stk_empty,
  input  logic              stk_valid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [OP_W-1:0] client_op [N];
  logic [W-1:0]    client_in [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_client
      assign client_op[gi] = req_op[4*gi +: 4];
      assign client_in[gi] = req_in[W*gi +: W];
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [N-1:0]    gnt_next, done_next;
  logic [W-1:0]    rsp_head_next, stk_in_next;
  logic            rsp_valid_next, rsp_empty_next, stk_apply_next;
  logic [OP_W-1:0] stk_op_next;

  logic [N-1:0]    pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            reject;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .eligible (req & ~done),
    .ptr      (ptr_reg),
    .grant    (pick_gnt),
    .idx      (pick_idx),
    .any      (pick_any)
  );

`ifdef STACK_ARB_GUARD_EN
  localparam int DW = $clog2(DEPTH + 1);
  logic [DW-1:0] depth_reg, depth_next;

  assign reject = (client_op[pick_idx] == OP_POP  && depth_reg == '0) ||
                  (client_op[pick_idx] == OP_PUSH && depth_reg == DW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) depth_reg <= '0;
    else     depth_reg <= depth_next;
  end
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= IW'(N - 1);
      gnt       <= '0;
      done      <= '0;
      rsp_head  <= '0;
      rsp_valid <= 1'b0;
      rsp_empty <= 1'b0;
      stk_in    <= '0;
      stk_op    <= '0;
      stk_apply <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gnt       <= gnt_next;
      done      <= done_next;
      rsp_head  <= rsp_head_next;
      rsp_valid <= rsp_valid_next;
      rsp_empty <= rsp_empty_next;
      stk_in    <= stk_in_next;
      stk_op    <= stk_op_next;
      stk_apply <= stk_apply_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gnt_next       = gnt;
    done_next      = '0;
    rsp_head_next  = rsp_head;
    rsp_valid_next = rsp_valid;
    rsp_empty_next = rsp_empty;
    stk_in_next    = stk_in;
    stk_op_next    = stk_op;
    stk_apply_next = 1'b0;
`ifdef STACK_ARB_GUARD_EN
    depth_next     = depth_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          ptr_next = pick_idx;
          if (reject) begin
            // Answered locally: the stack never sees this op.
            done_next      = pick_gnt;
            rsp_valid_next = 1'b0;
          end else begin
            gnt_next       = pick_gnt;
            stk_op_next    = client_op[pick_idx];
            stk_in_next    = client_in[pick_idx];
            stk_apply_next = 1'b1;
            state_next     = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_next = SETTLE;
      end
      SETTLE: begin
        rsp_head_next  = stk_head;
        rsp_valid_next = stk_valid;
        rsp_empty_next = stk_empty;
        done_next      = gnt;
        gnt_next       = '0;
        state_next     = IDLE;
`ifdef STACK_ARB_GUARD_EN
        if (stk_valid && stk_op == OP_PUSH) depth_next = depth_reg + DW'(1);
        if (stk_valid && stk_op == OP_POP)  depth_next = depth_reg - DW'(1);
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter (W=8, N=2, DEPTH=4) with a small behavioural stack.
// Guard-specific expectations follow STACK_ARB_GUARD_EN.
module tb_stack_arbiter;
  import stack_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [3:0]  op_c [2];
  logic [7:0]  in_c [2];
  logic [7:0]  req_op;
  logic [15:0] req_in;
  logic [1:0]  gnt, done;
  logic [7:0]  rsp_head, stk_in, stk_head;
  logic        rsp_valid, rsp_empty, stk_apply, stk_empty, stk_valid;
  logic [3:0]  stk_op;

  int compared   = 0;
  int mismatched = 0;

  assign req_op = {op_c[1], op_c[0]};
  assign req_in = {in_c[1], in_c[0]};

  always #5 clk = ~clk;

  stack_arbiter #(.W(8), .N(2), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_op    (req_op),
    .req_in    (req_in),
    .gnt       (gnt),
    .done      (done),
    .rsp_head  (rsp_head),
    .rsp_valid (rsp_valid),
    .rsp_empty (rsp_empty),
    .stk_in    (stk_in),
    .stk_op    (stk_op),
    .stk_apply (stk_apply),
    .stk_head  (stk_head),
    .stk_empty (stk_empty),
    .stk_valid (stk_valid)
  );

  // Behavioural 16-entry stack: outputs update on the edge that sees apply.
  logic [7:0] mem [16];
  logic [4:0] sp;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= 5'd0;
      stk_head  <= 8'd0;
      stk_valid <= 1'b0;
      stk_empty <= 1'b1;
    end else if (stk_apply) begin
      if (stk_op == OP_PUSH) begin
        if (sp < 5'd16) begin
          mem[sp[3:0]] <= stk_in;
          sp           <= sp + 5'd1;
          stk_head     <= stk_in;
          stk_valid    <= 1'b1;
          stk_empty    <= 1'b0;
        end else begin
          stk_valid <= 1'b0;
        end
      end else if (stk_op == OP_POP) begin
        if (sp != 5'd0) begin
          sp        <= sp - 5'd1;
          stk_head  <= (sp > 5'd1) ? mem[4'(sp - 5'd2)] : 8'd0;
          stk_valid <= 1'b1;
          stk_empty <= (sp == 5'd1);
        end else begin
          stk_valid <= 1'b0;
        end
      end else begin
        stk_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full issue/settle/response transaction for one client.
  task automatic do_op(input logic c, input logic [3:0] op, input logic [7:0] din,
                       input logic [7:0] eh, input logic ev, input logic ee);
    logic [1:0] oh;
    oh = c ? 2'b10 : 2'b01;
    op_c[c] = op;
    in_c[c] = din;
    req = req | oh;
    tick();
    chk("apply_hi", 32'(stk_apply), 32'd1);
    chk("gnt", 32'(gnt), 32'(oh));
    chk("stk_op", 32'(stk_op), 32'(op));
    chk("stk_in", 32'(stk_in), 32'(din));
    tick();
    chk("apply_lo", 32'(stk_apply), 32'd0);
    chk("done_early", 32'(done), 32'd0);
    tick();
    chk("done", 32'(done), 32'(oh));
    chk("gnt_clear", 32'(gnt), 32'd0);
    chk("rsp_head", 32'(rsp_head), 32'(eh));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("rsp_empty", 32'(rsp_empty), 32'(ee));
    req = req & ~oh;
    $display("op client=%0d op=%0d in=%0d -> head=%0d valid=%0d empty=%0d",
             c, op, din, rsp_head, rsp_valid, rsp_empty);
    tick();
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  // Locally rejected op: answered one cycle after sampling, stack untouched.
  task automatic do_reject(input logic c, input logic [3:0] op,
                           input logic [7:0] eh, input logic ee);
    logic [1:0] oh;
    oh = c ? 2'b10 : 2'b01;
    op_c[c] = op;
    req = req | oh;
    tick();
    chk("rej_apply", 32'(stk_apply), 32'd0);
    chk("rej_gnt", 32'(gnt), 32'd0);
    chk("rej_done", 32'(done), 32'(oh));
    chk("rej_valid", 32'(rsp_valid), 32'd0);
    chk("rej_head", 32'(rsp_head), 32'(eh));
    chk("rej_empty", 32'(rsp_empty), 32'(ee));
    req = req & ~oh;
    $display("reject client=%0d op=%0d -> done=%b valid=%0d", c, op, done, rsp_valid);
    tick();
    chk("rej_done_pulse", 32'(done), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b00;
    op_c[0] = 4'd0; op_c[1] = 4'd0;
    in_c[0] = 8'd0; in_c[1] = 8'd0;
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_apply", 32'(stk_apply), 32'd0);
    chk("rst_stk_in", 32'(stk_in), 32'd0);
    chk("rst_stk_op", 32'(stk_op), 32'd0);
    chk("rst_head", 32'(rsp_head), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_empty", 32'(rsp_empty), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single push.
    do_op(1'b0, OP_PUSH, 8'd22, 8'd22, 1'b1, 1'b0);

    // Pop on empty from client 1.
    do_reset();
`ifdef STACK_ARB_GUARD_EN
    do_reject(1'b1, OP_POP, 8'd0, 1'b0);
`else
    do_op(1'b1, OP_POP, 8'd0, 8'd0, 1'b0, 1'b1);
`endif

    // Contention: both request pushes continuously.
    op_c[0] = OP_PUSH; in_c[0] = 8'd5;
    op_c[1] = OP_PUSH; in_c[1] = 8'd9;
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      logic [1:0] e;
      e = (g % 2 == 1) ? 2'b10 : 2'b01;
      tick();
      chk("cont_gnt", 32'(gnt), 32'(e));
      chk("cont_apply", 32'(stk_apply), 32'd1);
      tick();
      tick();
      chk("cont_done", 32'(done), 32'(e));
      chk("cont_head", 32'(rsp_head), (e == 2'b10) ? 32'd9 : 32'd5);
      chk("cont_valid", 32'(rsp_valid), 32'd1);
      $display("contention grant=%b head=%0d", e, rsp_head);
    end
    req = 2'b00;
    tick();
    chk("cont_done_end", 32'(done), 32'd0);

`ifdef STACK_ARB_GUARD_EN
    // Depth is now 4 == DEPTH: a fifth push is refused.
    do_reject(1'b0, OP_PUSH, 8'd9, 1'b0);
`endif

    // Push/pop ordering.
    do_reset();
    do_op(1'b0, OP_PUSH, 8'd1, 8'd1, 1'b1, 1'b0);
    do_op(1'b0, OP_PUSH, 8'd2, 8'd2, 1'b1, 1'b0);
    do_op(1'b0, OP_PUSH, 8'd3, 8'd3, 1'b1, 1'b0);
    do_op(1'b0, OP_POP,  8'd0, 8'd2, 1'b1, 1'b0);
    do_op(1'b0, OP_POP,  8'd0, 8'd1, 1'b1, 1'b0);
    do_op(1'b0, OP_POP,  8'd0, 8'd0, 1'b1, 1'b1);
`ifdef STACK_ARB_GUARD_EN
    do_reject(1'b0, OP_POP, 8'd0, 1'b1);
`else
    do_op(1'b0, OP_POP,  8'd0, 8'd0, 1'b0, 1'b1);
`endif

    // Async reset during ISSUE.
    op_c[1] = OP_PUSH; in_c[1] = 8'd44;
    req = 2'b10;
    tick();
    chk("mid_apply_hi", 32'(stk_apply), 32'd1);
    chk("mid_gnt", 32'(gnt), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("mid_apply_async", 32'(stk_apply), 32'd0);
    chk("mid_gnt_async", 32'(gnt), 32'd0);
    req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_done", 32'(done), 32'd0);
    end
    $display("reset mid-op: done=%b apply=%0d", done, stk_apply);
    do_op(1'b0, OP_PUSH, 8'd66, 8'd66, 1'b1, 1'b0);

    // Illegal op code passes through; the stack reports it invalid.
    do_op(1'b1, 4'd7, 8'h33, 8'd66, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
